// File: rtl/parity_pop_stage.sv
// parity_pop_stage: parity-checking FIFO pop consumer with a 2-entry skid buffer and error counter.
// Optional macro PARITY_POP_HALT_EN stops input after the first corrupt word until err_clr_i.
module parity_pop_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int EVEN_ODD   = 0,
  parameter int PARITY_BIT = 0,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH:0]   pop_data_i,
  input  logic                  pop_valid_i,
  output logic                  pop_grant_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  err_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o,
  input  logic                  err_clr_i
);
  typedef enum logic {RUN, HALT} state_t;
  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [2];
  logic [DATA_WIDTH-1:0] payload;
  logic [1:0]            count, count_next;
  logic                  rd_ptr, wr_ptr;
  logic                  in_xfer, good, good_in, bad_in, out_xfer;
  assign in_xfer     = pop_valid_i & pop_grant_o;
  assign good        = (^pop_data_i) == 1'(EVEN_ODD);
  assign good_in     = in_xfer & good;
  assign bad_in      = in_xfer & ~good;
  assign payload     = (PARITY_BIT != 0) ? pop_data_i[DATA_WIDTH-1:0] : pop_data_i[DATA_WIDTH:1];
  assign out_valid_o = count != 2'd0;
  assign out_xfer    = out_valid_o & out_ready_i;
  assign out_data_o  = mem[rd_ptr];
  assign count_next  = count + {1'b0, good_in} - {1'b0, out_xfer};
  always_comb begin
    state_next = state;
`ifdef PARITY_POP_HALT_EN
    state_next = (state == RUN && bad_in) ? HALT : (state == HALT && err_clr_i) ? RUN : state;
`endif
  end
  // grant is registered from next-state values so out_ready_i never reaches pop_grant_o combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      count       <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      pop_grant_o <= 1'b0;
      err_o       <= 1'b0;
      err_cnt_o   <= '0;
      mem[0]      <= '0;
      mem[1]      <= '0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      pop_grant_o <= (count_next < 2'd2) && (state_next == RUN);
      err_o       <= bad_in;
      err_cnt_o   <= err_clr_i ? '0 : (bad_in && !(&err_cnt_o)) ? err_cnt_o + 1'b1 : err_cnt_o;
      if (good_in) begin
        mem[wr_ptr] <= payload;
        wr_ptr      <= ~wr_ptr;
      end
      if (out_xfer) rd_ptr <= ~rd_ptr;
    end
  end
endmodule
